// File: rtl/scr1_wb_arb_pkg.sv
// Shared types and constants for the SCR1 imem/dmem Wishbone arbiter.
//   type_scr1_wb_arb_state_e  : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   type_scr1_wb_arb_master_e : master identifiers used for grant tracking
//   SCR1_WB_ARB_RR / SCR1_WB_ARB_FIXED : ARB_MODE encodings
package scr1_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } type_scr1_wb_arb_state_e;

    typedef enum logic {
        MST_IMEM = 1'b0,
        MST_DMEM = 1'b1
    } type_scr1_wb_arb_master_e;

    localparam int SCR1_WB_ARB_RR    = 0;
    localparam int SCR1_WB_ARB_FIXED = 1;

endpackage : scr1_wb_arb_pkg

// File: rtl/scr1_wb_arb_rr.sv
// Two-way winner selector for the imem/dmem arbiter.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   req_imem/dmem    : pending requests from the two masters
//   update           : a grant is being issued this cycle; remember the winner
//   winner           : combinational winner among the current requests
// With ARB_MODE = SCR1_WB_ARB_FIXED dmem always wins a tie; otherwise a tie
// goes to the master that did not win the previous grant.
module scr1_wb_arb_rr
    import scr1_wb_arb_pkg::*;
#(
    parameter int ARB_MODE = SCR1_WB_ARB_RR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_imem,
    input  logic                     req_dmem,
    input  logic                     update,
    output type_scr1_wb_arb_master_e winner
);

    type_scr1_wb_arb_master_e last_grant;

    always_comb begin
        winner = MST_DMEM;
        if (req_imem && !req_dmem) begin
            winner = MST_IMEM;
        end else if (req_imem && req_dmem) begin
            if (ARB_MODE == SCR1_WB_ARB_FIXED) begin
                winner = MST_DMEM;
            end else begin
                winner = (last_grant == MST_DMEM) ? MST_IMEM : MST_DMEM;
            end
        end
    end

    // Reset to DMEM so that the first tie after reset goes to imem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= MST_DMEM;
        end else if (update) begin
            last_grant <= winner;
        end
    end

endmodule : scr1_wb_arb_rr

// File: rtl/scr1_wb_mem_arb.sv
// Two-master (SCR1 imem + dmem) to one-slave Wishbone classic arbiter.
// One transaction at a time: IDLE -> grant -> release on ack/err -> IDLE.
// Request fields are not registered: the granted master's request is muxed
// straight to the slave and the slave response straight back to it.
// Ports:
//   wb_clk, wb_rst           : clock, asynchronous active-high reset
//   wbd_imem_* / wbd_dmem_*  : master-side request inputs, response outputs
//   wbm_*                    : shared slave request outputs, response inputs
//   wb_arb_tmo_o             : sticky grant-timeout flag (macro only)
// Optional feature macro: SCR1_WB_ARB_TIMEOUT_EN -- grant watchdog of
// TIMEOUT_CYC cycles that errors the stuck master and frees the bus.
module scr1_wb_mem_arb
    import scr1_wb_arb_pkg::*;
#(
    parameter int SCR1_WB_WIDTH = 32,
    parameter int ARB_MODE      = SCR1_WB_ARB_RR,
    parameter int TIMEOUT_CYC   = 256
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,

    input  logic                     wbd_imem_stb_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_imem_adr_i,
    input  logic                     wbd_imem_we_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_imem_dat_i,
    input  logic [3:0]               wbd_imem_sel_i,
    output logic [SCR1_WB_WIDTH-1:0] wbd_imem_dat_o,
    output logic                     wbd_imem_ack_o,
    output logic                     wbd_imem_err_o,

    input  logic                     wbd_dmem_stb_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_dmem_adr_i,
    input  logic                     wbd_dmem_we_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_dmem_dat_i,
    input  logic [3:0]               wbd_dmem_sel_i,
    output logic [SCR1_WB_WIDTH-1:0] wbd_dmem_dat_o,
    output logic                     wbd_dmem_ack_o,
    output logic                     wbd_dmem_err_o,

    output logic                     wbm_stb_o,
    output logic [SCR1_WB_WIDTH-1:0] wbm_adr_o,
    output logic                     wbm_we_o,
    output logic [SCR1_WB_WIDTH-1:0] wbm_dat_o,
    output logic [3:0]               wbm_sel_o,
    input  logic [SCR1_WB_WIDTH-1:0] wbm_dat_i,
    input  logic                     wbm_ack_i,
    input  logic                     wbm_err_i
`ifdef SCR1_WB_ARB_TIMEOUT_EN
    ,
    output logic                     wb_arb_tmo_o
`endif
);

    if (ARB_MODE != SCR1_WB_ARB_RR && ARB_MODE != SCR1_WB_ARB_FIXED) begin : g_bad_mode
        $error("scr1_wb_mem_arb: ARB_MODE must be 0 or 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
        $error("scr1_wb_mem_arb: TIMEOUT_CYC must be at least 1");
    end

    type_scr1_wb_arb_state_e  state;
    type_scr1_wb_arb_state_e  state_next;
    type_scr1_wb_arb_master_e winner;
    logic                     arb_update;
    logic                     gnt_i;
    logic                     gnt_d;
    logic                     gnt_stb;
    logic                     rsp_done;
    logic                     tmo_hit;

    assign gnt_i    = (state == GNT_I);
    assign gnt_d    = (state == GNT_D);
    assign gnt_stb  = (gnt_i & wbd_imem_stb_i) | (gnt_d & wbd_dmem_stb_i);
    assign rsp_done = wbm_ack_i | wbm_err_i;

    scr1_wb_arb_rr #(
        .ARB_MODE (ARB_MODE)
    ) i_arb_rr (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .req_imem (wbd_imem_stb_i),
        .req_dmem (wbd_dmem_stb_i),
        .update   (arb_update),
        .winner   (winner)
    );

`ifdef SCR1_WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt;

    // tmo_cnt holds the number of completed grant cycles, so the cycle in
    // which it equals TIMEOUT_CYC-1 is the TIMEOUT_CYC-th grant cycle. The
    // slave response is deliberately left out of this term so that the
    // slave ack never feeds back into wbm_stb_o combinationally.
    assign tmo_hit = gnt_stb & (tmo_cnt == TMO_LAST);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            tmo_cnt      <= '0;
            wb_arb_tmo_o <= 1'b0;
        end else begin
            if (arb_update) begin
                tmo_cnt <= '0;
            end else if ((gnt_i | gnt_d) && !rsp_done) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (tmo_hit) begin
                wb_arb_tmo_o <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dropped stb while granted is an abort: release without a response.
    always_comb begin
        state_next = state;
        arb_update = 1'b0;
        case (state)
            IDLE: begin
                if (wbd_imem_stb_i || wbd_dmem_stb_i) begin
                    arb_update = 1'b1;
                    state_next = (winner == MST_IMEM) ? GNT_I : GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (rsp_done || !gnt_stb || tmo_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wbm_stb_o      = 1'b0;
        wbm_adr_o      = '0;
        wbm_we_o       = 1'b0;
        wbm_dat_o      = '0;
        wbm_sel_o      = '0;
        wbd_imem_dat_o = '0;
        wbd_imem_ack_o = 1'b0;
        wbd_imem_err_o = 1'b0;
        wbd_dmem_dat_o = '0;
        wbd_dmem_ack_o = 1'b0;
        wbd_dmem_err_o = 1'b0;
        if (gnt_i) begin
            wbm_stb_o      = wbd_imem_stb_i & ~tmo_hit;
            wbm_adr_o      = wbd_imem_adr_i;
            wbm_we_o       = wbd_imem_we_i;
            wbm_dat_o      = wbd_imem_dat_i;
            wbm_sel_o      = wbd_imem_sel_i;
            wbd_imem_dat_o = wbm_dat_i;
            wbd_imem_ack_o = wbm_ack_i;
            wbd_imem_err_o = wbm_err_i | tmo_hit;
        end else if (gnt_d) begin
            wbm_stb_o      = wbd_dmem_stb_i & ~tmo_hit;
            wbm_adr_o      = wbd_dmem_adr_i;
            wbm_we_o       = wbd_dmem_we_i;
            wbm_dat_o      = wbd_dmem_dat_i;
            wbm_sel_o      = wbd_dmem_sel_i;
            wbd_dmem_dat_o = wbm_dat_i;
            wbd_dmem_ack_o = wbm_ack_i;
            wbd_dmem_err_o = wbm_err_i | tmo_hit;
        end
    end

endmodule : scr1_wb_mem_arb
